i2c_target_byte: RTL
====================

Name: i2c_target_byte

Overview:
Byte-level I2C target engine sitting directly downstream of the bit-level I2C target MAC. It consumes sampled SDA bits and start/stop strobes, and matches the 7-bit address. It assembles write bytes for the user side and serialises read bytes back into the MAC bit-queue interface, including ACK generation and master ACK/NACK handling. There is no clock stretching: read data not ready in time is replaced by 0xFF.

Parameters:
TARGET_ADDR, 7'h42, 7-bit I2C address this target answers to.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i2c_rx_bit_data_i  in  1  SDA sample from MAC, valid when i2c_rx_bit_valid_i=1
i2c_rx_bit_valid_i  in  1  one-clk strobe per SCL rising edge
i2c_bus_start_i  in  1  start/repeated-start strobe from MAC
i2c_bus_stop_i  in  1  stop strobe from MAC
i2c_tx_bit_data_o  out  1  bit to queue in MAC (0 = pull SDA low)
i2c_tx_bit_valid_o  out  1  one-clk strobe loading i2c_tx_bit_data_o into MAC queue
rx_data_o  out  8  received write byte, MSB first on wire
rx_valid_o  out  1  one-clk strobe, rx_data_o valid
tx_data_i  in  8  next read byte from user
tx_valid_i  in  1  tx_data_i available
tx_ready_o  out  1  one-clk strobe: tx_data_i consumed this cycle
tx_underrun_o  out  1  one-clk strobe: read byte needed, tx_valid_i low, 0xFF sent
addressed_o  out  1  level: address matched, transaction active
rw_o  out  1  level: R/W bit of current transaction (1 = read)

Behaviour:
- Reset (async, rst=1): state IDLE; bit counter 0; all outputs 0 except rx_data_o=0. rst mid-transaction drops the transaction; tx_bit_valid_o=0, so the MAC releases SDA on its own.
- States: IDLE, ADDR, WDATA, RDATA, IGNORE. Bit counter cnt counts 0..8 inside a byte slot (8 data bits + ACK bit). It increments on each i2c_rx_bit_valid_i and wraps 8->0.
- Priority each clk: start > stop > rx bit. On start from any state -> ADDR, cnt=0, addressed_o=0; any same-cycle rx bit is ignored. On stop -> IDLE, addressed_o=0, rw_o held.
- All strobes to the MAC and user (i2c_tx_bit_valid_o, rx_valid_o, tx_ready_o, tx_underrun_o) are registered. Each asserts exactly 1 clk after the triggering i2c_rx_bit_valid_i cycle and lasts 1 clk.
- ADDR: shift bits MSB first into an 8-bit shift register. On the 8th bit (cnt=7), compare [7:1] with TARGET_ADDR.
  - Match: queue ACK (tx bit 0); set addressed_o=1 and rw_o=bit0.
  - Mismatch: no queue; go to IGNORE.
- ADDR ACK bit (cnt=8):
  - Write (rw=0): go to WDATA.
  - Read (rw=1): fetch a read byte and queue its bit7; go to RDATA.
- Fetch: if tx_valid_i=1, latch tx_data_i and pulse tx_ready_o. Otherwise latch 0xFF and pulse tx_underrun_o.
- WDATA:
  - cnt=0..7: shift bits in.
  - At cnt=7: rx_data_o <= assembled byte, pulse rx_valid_o, queue ACK 0. Every byte is ACKed; there is no backpressure.
  - At cnt=8: no queue.
- RDATA:
  - At cnt=k for k=0..6: queue byte bit (6-k).
  - At cnt=7: no queue, so SDA is released for the master ACK.
  - At cnt=8, sample i2c_rx_bit_data_i. 0 (ACK): fetch the next byte and queue its bit7. 1 (NACK): go to IGNORE, addressed_o=0.
- IGNORE: no queues; waits for start or stop.
- IDLE: rx bits are ignored.
- Only ACK and read-data zeros/ones are ever queued. Bits not queued are released to 1 by the MAC, which resets its queue after each SCL fall.

Test Plan:
- Write to 0x42: start, addr byte 0x84, data 0xA5, 0x3C, stop -> ACK queued after addr (i2c_tx_bit_data_o=0 one clk after 8th bit); rx_valid_o pulses with 0xA5 then 0x3C; both ACKed; addressed_o falls at stop.
- Address mismatch: start, 0x86 (addr 0x43), 0xFF -> no i2c_tx_bit_valid_o; no rx_valid_o; IGNORE until stop.
- Read 2 bytes: start, 0x85, tx_data_i=0x5A held valid; master ACKs byte 1 and NACKs byte 2 -> queued bits 0,1,0,1,1,0,1,0 per byte. tx_ready_o pulses twice; no queue after NACK; state IGNORE.
- Read underrun: start, 0x85, tx_valid_i=0 -> tx_underrun_o pulses once; no bits queued for 0xFF; tx_ready_o stays 0.
- Repeated start: write 0x84, 0x10, then start, 0x85 without stop -> cnt resets; rw_o switches 0->1; read proceeds.
- Start coincident with rx bit, and async rst asserted during 4th data bit -> bit ignored; cnt=0. After rst: all outputs 0, state IDLE, next start accepted normally.

Source files
------------

// File: rtl/i2c_target_byte.sv
// Byte-level I2C target engine: address match, write-byte assembly and
// read-byte serialisation into the bit queue of the downstream bit-level MAC.
//
// Handshakes: every strobe output (i2c_tx_bit_valid_o, rx_valid_o, tx_ready_o,
// tx_underrun_o) is registered and lasts exactly one clk, one clk after the
// i2c_rx_bit_valid_i cycle that caused it; tx_data_i is taken only in a cycle
// where tx_ready_o is then pulsed, there is no backpressure on rx_data_o.
module i2c_target_byte #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_rx_bit_data_i,
  input  logic       i2c_rx_bit_valid_i,
  input  logic       i2c_bus_start_i,
  input  logic       i2c_bus_stop_i,
  output logic       i2c_tx_bit_data_o,
  output logic       i2c_tx_bit_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       addressed_o,
  output logic       rw_o,
  output logic [2:0] debug_state,
  output logic [3:0] debug_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    RDATA  = 3'd3,
    IGNORE = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] shreg;
  logic [7:0] tx_byte;
  logic       tx_filler;

  logic [7:0] byte_in;
  logic [7:0] fetch_byte;
  logic [2:0] rd_idx;
  logic [3:0] cnt_next;

  always_comb begin
    byte_in    = {shreg, i2c_rx_bit_data_i};
    fetch_byte = tx_valid_i ? tx_data_i : 8'hFF;
    rd_idx     = 3'd6 - cnt[2:0];
    cnt_next   = (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
  end

  assign debug_state = state;
  assign debug_cnt   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      shreg              <= 7'd0;
      tx_byte            <= 8'd0;
      tx_filler          <= 1'b0;
      i2c_tx_bit_data_o  <= 1'b0;
      i2c_tx_bit_valid_o <= 1'b0;
      rx_data_o          <= 8'd0;
      rx_valid_o         <= 1'b0;
      tx_ready_o         <= 1'b0;
      tx_underrun_o      <= 1'b0;
      addressed_o        <= 1'b0;
      rw_o               <= 1'b0;
    end else begin
      i2c_tx_bit_valid_o <= 1'b0;
      rx_valid_o         <= 1'b0;
      tx_ready_o         <= 1'b0;
      tx_underrun_o      <= 1'b0;
      if (i2c_bus_start_i) begin
        state       <= ADDR;
        cnt         <= 4'd0;
        addressed_o <= 1'b0;
      end else if (i2c_bus_stop_i) begin
        state       <= IDLE;
        cnt         <= 4'd0;
        addressed_o <= 1'b0;
      end else if (i2c_rx_bit_valid_i && state != IDLE) begin
        cnt <= cnt_next;
        case (state)
          ADDR: begin
            if (cnt != 4'd8) shreg <= byte_in[6:0];
            if (cnt == 4'd7) begin
              if (shreg == TARGET_ADDR) begin
                i2c_tx_bit_data_o  <= 1'b0;
                i2c_tx_bit_valid_o <= 1'b1;
                addressed_o        <= 1'b1;
                rw_o               <= i2c_rx_bit_data_i;
              end else begin
                state <= IGNORE;
              end
            end else if (cnt == 4'd8) begin
              if (!rw_o) begin
                state <= WDATA;
              end else begin
                // First read byte: its MSB must be queued during the address ACK slot.
                tx_byte            <= fetch_byte;
                tx_filler          <= !tx_valid_i;
                tx_ready_o         <= tx_valid_i;
                tx_underrun_o      <= !tx_valid_i;
                i2c_tx_bit_data_o  <= fetch_byte[7];
                i2c_tx_bit_valid_o <= tx_valid_i;
                state              <= RDATA;
              end
            end
          end
          WDATA: begin
            if (cnt != 4'd8) shreg <= byte_in[6:0];
            if (cnt == 4'd7) begin
              rx_data_o          <= byte_in;
              rx_valid_o         <= 1'b1;
              i2c_tx_bit_data_o  <= 1'b0;
              i2c_tx_bit_valid_o <= 1'b1;
            end
          end
          RDATA: begin
            // Filler 0xFF bytes are never queued; the MAC releases SDA to 1 anyway.
            if (cnt <= 4'd6) begin
              i2c_tx_bit_data_o  <= tx_byte[rd_idx];
              i2c_tx_bit_valid_o <= !tx_filler;
            end else if (cnt == 4'd8) begin
              if (!i2c_rx_bit_data_i) begin
                tx_byte            <= fetch_byte;
                tx_filler          <= !tx_valid_i;
                tx_ready_o         <= tx_valid_i;
                tx_underrun_o      <= !tx_valid_i;
                i2c_tx_bit_data_o  <= fetch_byte[7];
                i2c_tx_bit_valid_o <= tx_valid_i;
              end else begin
                state       <= IGNORE;
                addressed_o <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
